// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-address width, stall FSM encoding and multi-cycle latency default
package cpu_pkg;
   localparam int REG_ADDR_W = 4;
   localparam int MC_LATENCY_DEF = 4;
   typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;
endpackage

// File: rtl/perf_counter.sv
// perf_counter: saturating up-counter with synchronous clear and increment enable
module perf_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: prioritised per-stage enables/clears for mem wait, branch flush, multi-cycle EX and load-use
module pipeline_stall_controller
   import cpu_pkg::*;
#(
   parameter int MC_LATENCY = MC_LATENCY_DEF,
   parameter int PERF_W     = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  idex_memread,
   input  logic [REG_ADDR_W-1:0] idex_rt,
   input  logic [REG_ADDR_W-1:0] ifid_rs,
   input  logic [REG_ADDR_W-1:0] ifid_rt,
   input  logic                  idex_mc,
   input  logic                  branch_taken,
   input  logic                  mem_req,
   input  logic                  mem_ready,
   input  logic                  perf_clr,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_write,
   output logic                  exmem_write,
   output logic                  memwb_write,
   output logic                  ifid_flush,
   output logic                  controls_clear,
   output logic                  exmem_clear,
   output logic                  mc_busy,
   output logic [PERF_W-1:0]     stall_cycles,
   output logic [PERF_W-1:0]     flush_count
);
   localparam logic [3:0] MC_INIT = 4'((MC_LATENCY > 1) ? MC_LATENCY - 2 : 0);
   state_t     state_q, state_d;
   logic [3:0] mc_cnt_q, mc_cnt_d;
   logic       run, freeze, br, mc_entry, mc_hold, load_use;
   assign run      = state_q == RUN;
   assign freeze   = mem_req && !mem_ready;
   assign br       = run && branch_taken;
   assign mc_entry = run && idex_mc && !branch_taken && (MC_LATENCY > 1);
   assign mc_hold  = !run && mc_cnt_q != 4'd0;
   assign load_use = run && idex_memread && (idex_rt == ifid_rs || idex_rt == ifid_rt);
   assign mc_busy  = !run;
   always_comb begin
      pc_write       = !rst;
      ifid_write     = !rst;
      idex_write     = !rst;
      exmem_write    = !rst;
      memwb_write    = !rst;
      ifid_flush     = 1'b0;
      controls_clear = 1'b0;
      exmem_clear    = 1'b0;
      state_d        = state_q;
      mc_cnt_d       = mc_cnt_q;
      if (!rst) begin
         if (freeze) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            memwb_write = 1'b0;
         end else if (br) begin
            ifid_flush     = 1'b1;
            controls_clear = 1'b1;
         end else if (mc_entry || mc_hold) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_clear = 1'b1;
            state_d     = MC_WAIT;
            mc_cnt_d    = mc_entry ? MC_INIT : mc_cnt_q - 4'd1;
         end else if (!run) begin
            state_d = RUN;
         end else if (load_use) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            controls_clear = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q  <= RUN;
         mc_cnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
      end
   perf_counter #(.W(PERF_W)) u_stall (
      .clk(clk), .rst(rst), .clr(perf_clr), .inc(!pc_write), .cnt(stall_cycles)
   );
   perf_counter #(.W(PERF_W)) u_flush (
      .clk(clk), .rst(rst), .clr(perf_clr), .inc(br && !freeze), .cnt(flush_count)
   );
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: directed vectors with hand-computed enables, clears and counter values
module tb_pipeline_stall_controller;
   logic clk = 1'b0, rst = 1'b0;
   logic idex_memread = 1'b0, idex_mc = 1'b0, branch_taken = 1'b0;
   logic mem_req = 1'b0, mem_ready = 1'b0, perf_clr = 1'b0;
   logic [3:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;
   logic pc_write, ifid_write, idex_write, exmem_write, memwb_write;
   logic ifid_flush, controls_clear, exmem_clear, mc_busy;
   logic [15:0] stall_cycles, flush_count;
   logic [8:0] outs;
   int checks = 0, errors = 0;
   localparam logic [8:0] DEF  = 9'b11111_0000;
   localparam logic [8:0] LU   = 9'b00111_0100;
   localparam logic [8:0] MCE  = 9'b00011_0010;
   localparam logic [8:0] MCW  = 9'b00011_0011;
   localparam logic [8:0] ADV  = 9'b11111_0001;
   localparam logic [8:0] FRZ  = 9'b00000_0000;
   localparam logic [8:0] FRZW = 9'b00000_0001;
   localparam logic [8:0] BR   = 9'b11111_1100;
   always #5 clk = ~clk;
   pipeline_stall_controller #(.MC_LATENCY(4), .PERF_W(16)) dut (
      .clk(clk), .rst(rst), .idex_memread(idex_memread), .idex_rt(idex_rt),
      .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_mc(idex_mc), .branch_taken(branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready), .perf_clr(perf_clr),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .exmem_write(exmem_write), .memwb_write(memwb_write), .ifid_flush(ifid_flush),
      .controls_clear(controls_clear), .exmem_clear(exmem_clear), .mc_busy(mc_busy),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );
   assign outs = {pc_write, ifid_write, idex_write, exmem_write, memwb_write,
                  ifid_flush, controls_clear, exmem_clear, mc_busy};
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic cyc();
      @(negedge clk);
   endtask
   task automatic outs_at(input string tag, input logic [8:0] exp);
      #1 check(tag, 32'(outs), 32'(exp));
   endtask
   task automatic cnts(input string tag, input int s, input int f);
      check({tag, "_stall"}, 32'(stall_cycles), 32'(s));
      check({tag, "_flush"}, 32'(flush_count), 32'(f));
   endtask
   initial begin
      #2 rst = 1'b1;
      idex_mc = 1'b1; branch_taken = 1'b1; mem_req = 1'b1; idex_memread = 1'b1;
      repeat (2) cyc();
      outs_at("reset_outs", 9'b0);
      cnts("reset", 0, 0);
      rst = 1'b0; idex_mc = 1'b0; branch_taken = 1'b0; mem_req = 1'b0; idex_memread = 1'b0;
      outs_at("idle", DEF);
      cyc(); cnts("idle", 0, 0);
      idex_memread = 1'b1; idex_rt = 4'd5; ifid_rs = 4'd5; ifid_rt = 4'd0;
      outs_at("lu_rs", LU);
      cyc(); cnts("lu_rs", 1, 0);
      ifid_rs = 4'd0; ifid_rt = 4'd5;
      outs_at("lu_rt", LU);
      cyc(); cnts("lu_rt", 2, 0);
      ifid_rs = 4'd3; ifid_rt = 4'd4;
      outs_at("lu_nomatch", DEF);
      cyc(); cnts("lu_nomatch", 2, 0);
      idex_memread = 1'b0; idex_mc = 1'b1;
      outs_at("mc_entry", MCE);
      cyc(); idex_mc = 1'b0; outs_at("mc_w2", MCW);
      cyc(); outs_at("mc_w1", MCW);
      cyc(); outs_at("mc_adv", ADV);
      cyc(); outs_at("mc_done", DEF); cnts("mc", 5, 0);
      idex_mc = 1'b1;
      outs_at("mcm_entry", MCE);
      cyc(); idex_mc = 1'b0; outs_at("mcm_w2", MCW);
      cyc(); mem_req = 1'b1; mem_ready = 1'b0; outs_at("mcm_frz1", FRZW);
      cyc(); outs_at("mcm_frz2", FRZW);
      cyc(); mem_req = 1'b0; outs_at("mcm_w1", MCW);
      cyc(); outs_at("mcm_adv", ADV);
      cyc(); outs_at("mcm_done", DEF); cnts("mcm", 10, 0);
      branch_taken = 1'b1; idex_memread = 1'b1; idex_rt = 4'd5; ifid_rs = 4'd5;
      outs_at("br_lu", BR);
      cyc(); cnts("br_lu", 10, 1);
      mem_req = 1'b1; mem_ready = 1'b0;
      outs_at("br_frz", FRZ);
      cyc(); cnts("br_frz", 11, 1);
      mem_req = 1'b0; idex_memread = 1'b0; idex_mc = 1'b1;
      outs_at("br_mc", BR);
      cyc(); branch_taken = 1'b0; idex_mc = 1'b0;
      outs_at("br_mc_after", DEF); cnts("br_mc", 11, 2);
      mem_req = 1'b1; mem_ready = 1'b1;
      outs_at("mem_ready", DEF);
      cyc(); mem_ready = 1'b0;
      repeat (65600) cyc();
      cnts("sat", 65535, 2);
      perf_clr = 1'b1;
      cyc(); perf_clr = 1'b0; cnts("clr", 0, 0);
      cyc(); cnts("post_clr", 1, 0);
      mem_req = 1'b0; idex_mc = 1'b1;
      cyc(); idex_mc = 1'b0; outs_at("rmc_w2", MCW);
      #2 rst = 1'b1;
      #1 check("rst_mid_outs", 32'(outs), 32'(9'b0));
      cyc(); rst = 1'b0;
      outs_at("rst_mid_idle", DEF);
      cyc(); outs_at("rst_mid_run", DEF); cnts("rst_mid", 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
